mem_access_ctrl: RTL

- Memory-stage controller directly downstream of the execute stage.
- Consumes the ALU result as the data address, and Read Data 2 as store data.
- Sequences one access at a time to an external multi-cycle data memory through a request/done handshake.
- Stalls the pipeline until the access completes, registers load data, and traps on halt, misaligned access, illegal control or memory timeout.

---
 rtl/mem_access_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: issues one load/store at a time to a multi-cycle data
// memory, stalls the pipeline until it completes, and traps on halt or error.
module mem_access_ctrl #(
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        Halt,
  input  logic        MemDone,
  input  logic [15:0] MemRdData,
  output logic        MemEn,
  output logic        MemWr,
  output logic [15:0] MemAddr,
  output logic [15:0] MemWrData,
  output logic [15:0] ReadData,
  output logic        Stall,
  output logic        Halted,
  output logic        Err
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_TRAP} state_t;

  localparam logic [3:0] LAST_WAIT = 4'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        halted_q, halted_d;
  logic        err_q, err_d;

  logic req, bad_req, valid_req;

  always_comb begin
    req       = MemRead | MemWrite;
    bad_req   = (MemRead & MemWrite) | (req & Addr[0]);
    valid_req = req & ~bad_req & ~Halt;

    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    halted_d = halted_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (Halt) begin
          state_d  = S_TRAP;
          halted_d = 1'b1;
        end else if (bad_req) begin
          state_d  = S_TRAP;
          halted_d = 1'b1;
          err_d    = 1'b1;
        end else if (req) begin
          state_d = S_ACCESS;
          cnt_d   = '0;
          wr_d    = MemWrite;
          addr_d  = Addr;
          wdata_d = WriteData;
        end
      end
      S_ACCESS: begin
        if (MemDone) begin
          if (!wr_q) rdata_d = MemRdData;
          state_d = S_DONE;
        end else if (cnt_q == LAST_WAIT) begin
          state_d  = S_TRAP;
          halted_d = 1'b1;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      // DONE always returns to IDLE so the still-present request is not re-issued
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    MemEn     = (state_q == S_ACCESS);
    MemWr     = (state_q == S_ACCESS) & wr_q;
    MemAddr   = addr_q;
    MemWrData = wdata_q;
    ReadData  = rdata_q;
    Halted    = halted_q;
    Err       = err_q;
    Stall     = ((state_q == S_IDLE) & valid_req) | (state_q == S_ACCESS);
  end

endmodule
